// File: rtl/dma_cfg_tx_pkg.sv
// Shared definitions for the configuration-packet transmitter: beat flags,
// beat width, default opcode, FSM states and the command record.
package dma_cfg_tx_pkg;

  localparam int         CFG_W          = 134;
  localparam logic [5:0] BEAT_HEAD      = 6'b010000;
  localparam logic [5:0] BEAT_MID       = 6'b110000;
  localparam logic [5:0] BEAT_TAIL      = 6'b100000;
  localparam logic [2:0] OPCODE_DEFAULT = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_TAIL
  } state_t;

  // One queued write command; field order matches the beat layout below.
  typedef struct packed {
    logic [7:0]  dst;
    logic [7:0]  cmd_type;
    logic [31:0] addr;
    logic [31:0] mask;
    logic [31:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Head and tail share bits [127:32]; only the tail blanks the data field.
  function automatic logic [CFG_W-1:0] build_beat(input logic [5:0] flag,
                                                  input logic [2:0] opcode,
                                                  input cmd_t       cmd,
                                                  input logic       with_data);
    build_beat = {flag, 1'b1, opcode, 12'h000, cmd.dst, cmd.cmd_type,
                  cmd.addr, cmd.mask, (with_data ? cmd.data : 32'h0)};
  endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Small synchronous command FIFO with full/empty flags. The read port is
// asynchronous so the transmitter can form the head beat straight from the
// oldest entry without an extra prefetch cycle.
module cfg_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dma_cfg_tx.sv
// Turns queued register-write commands into two-beat (head, tail) packets on
// the pipeline configuration chain, honouring downstream backpressure.
module dma_cfg_tx
  import dma_cfg_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] OPCODE     = OPCODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_dst,
  input  logic [7:0]       cmd_type,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_mask,
  input  logic [31:0]      cmd_data,
  output logic [CFG_W-1:0] cout_cfg_data,
  output logic             cout_cfg_data_wr,
  input  logic             cin_cfg_ready,
  output logic             busy,
  output logic [15:0]      pkt_cnt
);

  state_t           r_state;
  state_t           w_state_next;
  cmd_t             w_cmd_in;
  cmd_t             w_fifo_dout;
  cmd_t             r_cmd;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic             w_tail_issue;
  logic [CFG_W-1:0] w_beat;
  logic             r_init;
  logic             r_wr;
  logic [CFG_W-1:0] r_data;
  logic [15:0]      r_pkt_cnt;

  // r_init keeps cmd_ready low until the first edge after reset releases.
  assign cmd_ready        = r_init && !w_fifo_full;
  assign w_push           = cmd_valid && cmd_ready;
  assign w_cmd_in         = {cmd_dst, cmd_type, cmd_addr, cmd_mask, cmd_data};
  assign w_tail_issue     = w_issue && (r_state == ST_TAIL);
  assign busy             = !w_fifo_empty || (r_state != ST_IDLE);
  assign cout_cfg_data    = r_data;
  assign cout_cfg_data_wr = r_wr;
  assign pkt_cnt          = r_pkt_cnt;

  cfg_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_cmd_in),
    .rd_en   (w_pop),
    .rd_data (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, beat selection and issue/pop strobes; a beat only issues when downstream is ready.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_pop        = 1'b0;
    w_beat       = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) w_state_next = ST_HEAD;
      end
      ST_HEAD: begin
        w_beat = build_beat(BEAT_HEAD, OPCODE, w_fifo_dout, 1'b1);
        if (cin_cfg_ready) begin
          w_issue      = 1'b1;
          w_pop        = 1'b1;
          w_state_next = ST_TAIL;
        end
      end
      ST_TAIL: begin
        w_beat = build_beat(BEAT_TAIL, OPCODE, r_cmd, 1'b0);
        if (cin_cfg_ready) begin
          w_issue      = 1'b1;
          w_state_next = w_fifo_empty ? ST_IDLE : ST_HEAD;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Hold the popped command so the tail can be rebuilt after the FIFO moves on.
  always_ff @(posedge clk) begin
    if (rst)        r_cmd <= '0;
    else if (w_pop) r_cmd <= w_fifo_dout;
  end

  // Registered beat output (zero when idle) and the completed-packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init    <= 1'b0;
      r_wr      <= 1'b0;
      r_data    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_init <= 1'b1;
      r_wr   <= w_issue;
      r_data <= w_issue ? w_beat : '0;
      if (w_tail_issue) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dma_cfg_tx.sv
// Scoreboard bench for dma_cfg_tx: stimulus queues expected beats, a monitor
// pops and compares every beat the DUT writes.
module tb_dma_cfg_tx;

  typedef struct packed {
    logic [7:0]  dst;
    logic [7:0]  typ;
    logic [31:0] addr;
    logic [31:0] mask;
    logic [31:0] data;
  } tcmd_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [7:0]   cmd_dst = '0;
  logic [7:0]   cmd_type = '0;
  logic [31:0]  cmd_addr = '0;
  logic [31:0]  cmd_mask = '0;
  logic [31:0]  cmd_data = '0;
  logic [133:0] cout_cfg_data;
  logic         cout_cfg_data_wr;
  logic         cin_cfg_ready = 1'b0;
  logic         busy;
  logic [15:0]  pkt_cnt;

  int           n_tests = 0;
  int           n_fail = 0;
  int           n_beats = 0;
  logic         mon_en = 1'b0;
  logic [133:0] sb [$];
  tcmd_t        vec [8];

  dma_cfg_tx #(
    .FIFO_DEPTH (4),
    .OPCODE     (3'b010)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dst          (cmd_dst),
    .cmd_type         (cmd_type),
    .cmd_addr         (cmd_addr),
    .cmd_mask         (cmd_mask),
    .cmd_data         (cmd_data),
    .cout_cfg_data    (cout_cfg_data),
    .cout_cfg_data_wr (cout_cfg_data_wr),
    .cin_cfg_ready    (cin_cfg_ready),
    .busy             (busy),
    .pkt_cnt          (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [133:0] mk_beat(input logic head, input tcmd_t c);
    logic [133:0] b;
    b            = '0;
    b[133:128]   = head ? 6'b010000 : 6'b100000;
    b[127]       = 1'b1;
    b[126:124]   = 3'b010;
    b[111:104]   = c.dst;
    b[103:96]    = c.typ;
    b[95:64]     = c.addr;
    b[63:32]     = c.mask;
    b[31:0]      = head ? c.data : 32'h0;
    return b;
  endfunction

  task automatic expect_pkt(input tcmd_t c);
    sb.push_back(mk_beat(1'b1, c));
    sb.push_back(mk_beat(1'b0, c));
  endtask

  task automatic push(input tcmd_t c);
    cmd_dst   = c.dst;
    cmd_type  = c.typ;
    cmd_addr  = c.addr;
    cmd_mask  = c.mask;
    cmd_data  = c.data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy && !cout_cfg_data_wr) break;
    end
    chk({name, "_drain"}, 134'(i == 200), 134'd0);
    sb.delete();
  endtask

  // Monitor: every written beat must match the next expected one; idle data must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cout_cfg_data_wr === 1'b1) begin
        n_beats++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got %h want none", cout_cfg_data);
        end else begin
          logic [133:0] e;
          e = sb.pop_front();
          $display("[TB] beat %0d data=%h", n_beats, cout_cfg_data);
          chk("beat", cout_cfg_data, e);
        end
      end else if (cout_cfg_data !== '0) begin
        chk("idle_data_zero", cout_cfg_data, '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{dst: 8'd70, typ: 8'd61, addr: 32'h00010001, mask: 32'hFFFFFFFF, data: 32'h00004000};
    vec[1] = '{dst: 8'h11, typ: 8'h22, addr: 32'hDEADBEEF, mask: 32'h0000FFFF, data: 32'h12345678};
    vec[2] = '{dst: 8'hA5, typ: 8'h5A, addr: 32'h00000004, mask: 32'hFF00FF00, data: 32'hCAFEF00D};
    vec[3] = '{dst: 8'hFF, typ: 8'h00, addr: 32'hFFFFFFFC, mask: 32'h00000001, data: 32'h00000001};
    vec[4] = '{dst: 8'h01, typ: 8'hFE, addr: 32'h80000000, mask: 32'h80000000, data: 32'hFFFFFFFF};
    vec[5] = '{dst: 8'h3C, typ: 8'hC3, addr: 32'h0000ABCD, mask: 32'h0F0F0F0F, data: 32'hA5A5A5A5};
    vec[6] = '{dst: 8'h07, typ: 8'h70, addr: 32'h13572468, mask: 32'hFFFF0000, data: 32'h0BADC0DE};
    vec[7] = '{dst: 8'h99, typ: 8'h66, addr: 32'h24681357, mask: 32'h00FF00FF, data: 32'h76543210};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", cout_cfg_data_wr, 0);
    chk("rst_data", cout_cfg_data, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", cmd_ready, 1);

    // Single command with hand-computed head/tail beats and latency
    cin_cfg_ready = 1'b1;
    sb.push_back(134'h10A000463D00010001FFFFFFFF00004000);
    sb.push_back(134'h20A000463D00010001FFFFFFFF00000000);
    push(vec[0]);
    @(negedge clk); chk("lat_k0", cout_cfg_data_wr, 0);
    @(negedge clk); chk("lat_k1", cout_cfg_data_wr, 0);
    @(negedge clk); chk("lat_head", cout_cfg_data_wr, 1);
    @(negedge clk); chk("lat_tail", cout_cfg_data_wr, 1);
    wait_idle("single");
    chk("single_pkt_cnt", pkt_cnt, 16'd1);

    // Four back-to-back commands: eight consecutive beats, no stall on intake
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) expect_pkt(vec[i]);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          chk("b2b_cmd_ready", cmd_ready, 1);
          push(vec[i]);
        end
      end
      begin
        int run;
        logic seen;
        run  = 0;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
          @(negedge clk);
          if (cout_cfg_data_wr) seen = 1'b1;
        end
        while (seen && cout_cfg_data_wr && run < 20) begin
          run++;
          @(negedge clk);
        end
        chk("b2b_run", run, 8);
      end
    join
    wait_idle("b2b");
    chk("b2b_pkt_cnt", pkt_cnt, 16'd5);

    // Six commands with downstream stalled: four accepted, two dropped
    @(posedge clk); #1;
    cin_cfg_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("full_cmd_ready_%0d", i), cmd_ready, (i < 4) ? 1 : 0);
      if (i < 4) expect_pkt(vec[i + 2]);
      push(vec[i + 2]);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("full_stall_no_beats", n_beats, 10);
    cin_cfg_ready = 1'b1;
    wait_idle("full");
    chk("full_pkt_cnt", pkt_cnt, 16'd9);

    // Ready 1,0,1 across one packet: head, gap, tail
    @(posedge clk); #1;
    expect_pkt(vec[7]);
    push(vec[7]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cin_cfg_ready = 1'b0;
    @(negedge clk); chk("gap_head", cout_cfg_data_wr, 1);
    @(posedge clk); #1;
    cin_cfg_ready = 1'b1;
    @(negedge clk); chk("gap_hole", cout_cfg_data_wr, 0);
    @(negedge clk); chk("gap_tail", cout_cfg_data_wr, 1);
    wait_idle("gap");
    chk("gap_pkt_cnt", pkt_cnt, 16'd10);

    // Reset right after a head beat: tail suppressed, counter cleared
    @(posedge clk); #1;
    sb.push_back(mk_beat(1'b1, vec[1]));
    push(vec[1]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_wr", cout_cfg_data_wr, 0);
    chk("mrst_data", cout_cfg_data, 0);
    chk("mrst_pkt_cnt", pkt_cnt, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("mrst_ready_back", cmd_ready, 1);
    chk("mrst_no_tail", sb.size(), 0);
    expect_pkt(vec[6]);
    push(vec[6]);
    wait_idle("mrst");
    chk("mrst_pkt_cnt_after", pkt_cnt, 16'd1);

    // Counter wrap from FFFF
    @(posedge clk); #1;
    force dut.r_pkt_cnt = 16'hFFFF;
    #1;
    release dut.r_pkt_cnt;
    expect_pkt(vec[5]);
    push(vec[5]);
    wait_idle("wrap");
    chk("wrap_pkt_cnt", pkt_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_cfg_tx.md
DMA_CFG_TX -- requirements
Module: dma_cfg_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO depth; power of two, minimum 2.
REQ-002 Parameter OPCODE, default 3'b010, write opcode placed in every packet.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 cmd_valid  input  1  command offered this cycle.
REQ-006 cmd_ready  output  1  command FIFO not full.
REQ-007 cmd_dst  input  8  destination module id.
REQ-008 cmd_type  input  8  table/register-type id.
REQ-009 cmd_addr  input  32  register address.
REQ-010 cmd_mask  input  32  write bit-mask.
REQ-011 cmd_data  input  32  write data.
REQ-012 cout_cfg_data  output  134  configuration beat toward the pipeline config chain.
REQ-013 cout_cfg_data_wr  output  1  cout_cfg_data valid this cycle.
REQ-014 cin_cfg_ready  input  1  downstream can take a beat at the next edge.
REQ-015 busy  output  1  FIFO non-empty or packet in flight.
REQ-016 pkt_cnt  output  16  packets fully sent, wraps at 16'hFFFF -> 0.

Function
REQ-017 Command accepted at an edge where cmd_valid and cmd_ready are both high; written into the FIFO.
REQ-018 cmd_ready = FIFO not full, from registered state only; no bypass when full, even if a pop occurs in the same cycle.
REQ-019 cmd_valid while cmd_ready is low: command dropped, no state change.
REQ-020 Each command becomes a 2-beat packet: head, then tail.
REQ-021 Head beat layout: [133:128]=6'b010000, [127]=1, [126:124]=OPCODE, [123:112]=0, [111:104]=dst, [103:96]=type, [95:64]=addr, [63:32]=mask, [31:0]=data.
REQ-022 Tail beat: [133:128]=6'b100000; [127:32] identical to head; [31:0]=0.
REQ-023 FSM states and transitions:
- IDLE -> HEAD when the FIFO is non-empty.
- HEAD -> TAIL when the head beat is issued.
- TAIL -> HEAD when the tail beat is issued and the FIFO is non-empty; TAIL -> IDLE otherwise.
REQ-024 A beat is issued at an edge only if cin_cfg_ready is sampled high at that edge; cout_cfg_data_wr is registered and high for exactly one cycle per beat.
REQ-025 cin_cfg_ready low: no beat issued, state and registered command held; cout_cfg_data_wr = 0 in the following cycle.
REQ-026 FIFO popped at the edge the head beat issues; the command is held in a register for the tail.
REQ-027 Latency: command accepted at edge k into an empty, idle block with ready high -> head wr high after edge k+2, tail after edge k+3.
REQ-028 Throughput: back-to-back packets at 2 cycles per packet with ready constantly high; no idle gap between tail and next head.
REQ-029 pkt_cnt increments at the edge the tail issues.
REQ-030 cout_cfg_data is don't-care when wr = 0, but is driven as 0.

Reset
REQ-031 While rst is high at an edge: FSM -> IDLE, FIFO emptied, cout_cfg_data_wr = 0, cout_cfg_data = 0, pkt_cnt = 0, busy = 0, cmd_ready = 0.
REQ-032 cmd_ready = 1 from the first edge after rst deasserts.
REQ-033 Reset mid-packet (after head, before tail): the tail is never issued and pkt_cnt is not incremented.

Structure
REQ-034 Shared package holds: beat-flag constants (HEAD=6'b010000, MID=6'b110000, TAIL=6'b100000), the 134-bit width, the OPCODE default, and the FSM state enum.
REQ-035 One sub-module, cfg_cmd_fifo: synchronous, parameterized width/depth, with full/empty flags.

Verification
REQ-036 Single command (dst=70, type=61, addr=32'h00010001, mask=32'hFFFFFFFF, data=32'h00004000), ready high -> head then tail on consecutive cycles with exact REQ-021/022 values; pkt_cnt=1.
REQ-037 Four commands pushed back-to-back, ready high -> 8 consecutive wr cycles in order; cmd_ready never low; pkt_cnt=4.
REQ-038 Six commands pushed with ready held low -> cmd_ready falls after 4 accepted; commands 5-6 dropped; on ready high, exactly 4 packets emerge.
REQ-039 Ready toggled 1,0,1 across a packet -> head, one-cycle gap, tail with unchanged data; no duplicate beats.
REQ-040 rst asserted the cycle after a head beat -> no tail, wr=0, pkt_cnt=0, busy=0; a new command afterwards produces a correct packet.
REQ-041 pkt_cnt preloaded via force to 16'hFFFF, one packet sent -> pkt_cnt reads 0.
